// File: rtl/palette_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : palette_ram_arbiter_if
//  Description : Video lookup, CPU access and colour-RAM bus bundle for the
//                palette RAM arbiter.
//  Revision    : 1.0
// ============================================================================
interface palette_ram_arbiter_if #(
    parameter int AW = 13,
    parameter int DW = 16
);
    logic          ce_pixel;
    logic          vblank;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;

    logic          cpu_req;
    logic          cpu_we;
    logic [1:0]    cpu_be;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [1:0]    ram_we;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  ce_pixel, vblank, vid_addr,
        input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        input  ram_rdata,
        output vid_data, vid_valid, cpu_ack, cpu_rdata,
        output ram_addr, ram_wdata, ram_we
    );

    modport master (
        output ce_pixel, vblank, vid_addr,
        output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        output ram_rdata,
        input  vid_data, vid_valid, cpu_ack, cpu_rdata,
        input  ram_addr, ram_wdata, ram_we
    );
endinterface
`default_nettype wire

// File: rtl/palette_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : palette_ram_arbiter
//  Description : Shares a single-port palette RAM between per-pixel video
//                lookups and buffered CPU accesses issued in idle clocks.
//  Revision    : 1.0
// ============================================================================
module palette_ram_arbiter #(
    parameter int AW         = 13,
    parameter int DW         = 16,
    parameter int RAM_LAT    = 1,
    parameter int BLANK_ONLY = 0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    palette_ram_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PEND   = 3'd1,
        S_RDWAIT = 3'd2,
        S_ACK    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] c_TAG_NONE = 2'd0;
    localparam logic [1:0] c_TAG_VID  = 2'd1;
    localparam logic [1:0] c_TAG_CPU  = 2'd2;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_buf_we;
    logic [1:0]            r_buf_be;
    logic [AW-1:0]         r_buf_addr;
    logic [DW-1:0]         r_buf_wdata;
    logic [AW-1:0]         r_last_vid;
    logic [DW-1:0]         r_vid_data;
    logic                  r_vid_valid;
    logic [DW-1:0]         r_cpu_rdata;
    logic [2*RAM_LAT-1:0]  r_tag_pipe;

    logic                  w_gate;
    logic                  w_cpu_slot;
    logic [1:0]            w_tag_in;
    logic [1:0]            w_tag_out;
    logic [AW-1:0]         w_ram_addr;
    logic [1:0]            w_ram_we;

    assign w_gate     = (BLANK_ONLY == 0) || bus.vblank;
    assign w_cpu_slot = !bus.ce_pixel && (r_state == S_PEND) && w_gate;
    assign w_tag_in   = bus.ce_pixel                ? c_TAG_VID :
                        (w_cpu_slot && !r_buf_we)   ? c_TAG_CPU : c_TAG_NONE;
    assign w_tag_out  = r_tag_pipe[2*RAM_LAT-1 -: 2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ram_addr  = r_last_vid;
        w_ram_we    = 2'b00;

        if (bus.ce_pixel) begin
            w_ram_addr = bus.vid_addr;
        end else if (w_cpu_slot) begin
            w_ram_addr = r_buf_addr;
            if (r_buf_we) begin
                w_ram_we = r_buf_be;
            end
        end

        case (r_state)
            S_IDLE:   if (bus.cpu_req) w_state_nxt = S_PEND;
            S_PEND:   if (w_cpu_slot)  w_state_nxt = r_buf_we ? S_ACK : S_RDWAIT;
            S_RDWAIT: if (w_tag_out == c_TAG_CPU) w_state_nxt = S_ACK;
            S_ACK:    w_state_nxt = S_DONE;
            // A request left high after its ack must not run a second time.
            S_DONE:   if (!bus.cpu_req) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_we    <= 1'b0;
            r_buf_be    <= 2'b00;
            r_buf_addr  <= '0;
            r_buf_wdata <= '0;
        end else if ((r_state == S_IDLE) && bus.cpu_req) begin
            r_buf_we    <= bus.cpu_we;
            r_buf_be    <= bus.cpu_be;
            r_buf_addr  <= bus.cpu_addr;
            r_buf_wdata <= bus.cpu_wdata;
        end
    end

    // Each tag follows its read through the RAM so the returning word is routed to its owner.
    generate
        if (RAM_LAT == 1) begin : g_tag_lat1
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_tag_pipe <= '0;
                end else begin
                    r_tag_pipe <= w_tag_in;
                end
            end
        end else begin : g_tag_latn
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_tag_pipe <= '0;
                end else begin
                    r_tag_pipe <= {r_tag_pipe[2*RAM_LAT-3:0], w_tag_in};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_vid  <= '0;
            r_vid_data  <= '0;
            r_vid_valid <= 1'b0;
            r_cpu_rdata <= '0;
        end else begin
            if (bus.ce_pixel) begin
                r_last_vid <= bus.vid_addr;
            end
            r_vid_valid <= (w_tag_out == c_TAG_VID);
            if (w_tag_out == c_TAG_VID) begin
                r_vid_data <= bus.ram_rdata;
            end
            if (w_tag_out == c_TAG_CPU) begin
                r_cpu_rdata <= bus.ram_rdata;
            end
        end
    end

    assign bus.ram_addr  = w_ram_addr;
    assign bus.ram_we    = w_ram_we;
    assign bus.ram_wdata = r_buf_wdata;
    assign bus.vid_data  = r_vid_data;
    assign bus.vid_valid = r_vid_valid;
    assign bus.cpu_ack   = (r_state == S_ACK);
    assign bus.cpu_rdata = r_cpu_rdata;
endmodule
`default_nettype wire

// File: tb/tb_palette_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_palette_ram_arbiter
//  Description : Bench for palette_ram_arbiter; instance A (RAM_LAT=1) and
//                instance B (RAM_LAT=2, BLANK_ONLY=1) against a cycle model.
//  Revision    : 1.0
// ============================================================================
module tb_palette_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_preload = 1'b1;
    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_bad = 0;

    logic        ce = 1'b0;
    logic        vblank = 1'b0;
    logic [12:0] vaddr = 13'h0123;
    int          ce_mode = 0;

    logic        req  [2];
    logic        cwe  [2];
    logic [1:0]  cbe  [2];
    logic [12:0] caddr[2];
    logic [15:0] cwd  [2];

    logic [12:0] o_addr [2];
    logic [1:0]  o_we   [2];
    logic [15:0] o_wd   [2];
    logic        o_ack  [2];
    logic [15:0] o_rdata[2];
    logic        o_vv   [2];
    logic [15:0] o_vd   [2];

    logic [15:0] ram [2][8192];
    logic [15:0] rd1 [2];
    logic [15:0] rd2 [2];
    int          wr_cnt [2];
    int          wr_cyc [2];
    int          ack_cnt[2];

    palette_ram_arbiter_if #(.AW(13), .DW(16)) bus_a ();
    palette_ram_arbiter_if #(.AW(13), .DW(16)) bus_b ();

    palette_ram_arbiter #(.AW(13), .DW(16), .RAM_LAT(1), .BLANK_ONLY(0)) u_dut_a (
        .clk(clk), .reset(rst), .bus(bus_a.slave));
    palette_ram_arbiter #(.AW(13), .DW(16), .RAM_LAT(2), .BLANK_ONLY(1)) u_dut_b (
        .clk(clk), .reset(rst), .bus(bus_b.slave));

    assign bus_a.ce_pixel = ce;      assign bus_b.ce_pixel = ce;
    assign bus_a.vblank   = vblank;  assign bus_b.vblank   = vblank;
    assign bus_a.vid_addr = vaddr;   assign bus_b.vid_addr = vaddr;
    assign bus_a.cpu_req  = req[0];  assign bus_b.cpu_req  = req[1];
    assign bus_a.cpu_we   = cwe[0];  assign bus_b.cpu_we   = cwe[1];
    assign bus_a.cpu_be   = cbe[0];  assign bus_b.cpu_be   = cbe[1];
    assign bus_a.cpu_addr = caddr[0]; assign bus_b.cpu_addr = caddr[1];
    assign bus_a.cpu_wdata = cwd[0]; assign bus_b.cpu_wdata = cwd[1];
    assign bus_a.ram_rdata = rd1[0]; assign bus_b.ram_rdata = rd2[1];

    assign o_addr[0] = bus_a.ram_addr;   assign o_addr[1] = bus_b.ram_addr;
    assign o_we[0]   = bus_a.ram_we;     assign o_we[1]   = bus_b.ram_we;
    assign o_wd[0]   = bus_a.ram_wdata;  assign o_wd[1]   = bus_b.ram_wdata;
    assign o_ack[0]  = bus_a.cpu_ack;    assign o_ack[1]  = bus_b.cpu_ack;
    assign o_rdata[0] = bus_a.cpu_rdata; assign o_rdata[1] = bus_b.cpu_rdata;
    assign o_vv[0]   = bus_a.vid_valid;  assign o_vv[1]   = bus_b.vid_valid;
    assign o_vd[0]   = bus_a.vid_data;   assign o_vd[1]   = bus_b.vid_data;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Colour RAMs: A returns data 1 clock after the address, B 2 clocks.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_preload) begin
                ram[k][13'h0123] <= 16'hBEEF;
                ram[k][13'h0010] <= 16'h0000;
                ram[k][13'h0020] <= 16'h0000;
                ram[k][13'h0030] <= 16'h0000;
                ram[k][13'h0040] <= 16'h0000;
                wr_cnt[k] <= 0;
                wr_cyc[k] <= -1;
            end else begin
                if (o_we[k][0]) ram[k][o_addr[k]][7:0]  <= o_wd[k][7:0];
                if (o_we[k][1]) ram[k][o_addr[k]][15:8] <= o_wd[k][15:8];
                if (o_we[k] != 2'b00) begin
                    wr_cnt[k] <= wr_cnt[k] + 1;
                    wr_cyc[k] <= cyc;
                end
            end
            rd1[k] <= ram[k][o_addr[k]];
            rd2[k] <= rd1[k];
        end
    end

    // Transaction-level model: which agent owns each clock, when each result is due.
    logic [15:0] mmem [2][8192];
    int          phase [2];     // 0 free, 1 buffered, 2 issued, 3 acked awaiting release
    logic        b_we  [2];
    logic [1:0]  b_be  [2];
    logic [12:0] b_addr[2];
    logic [15:0] b_wd  [2];
    int          ack_at[2];
    logic [15:0] rd_val[2];
    logic [15:0] mvd   [2];
    logic [15:0] mcr   [2];
    logic [12:0] mlast [2];
    logic        pv    [2][4];
    logic [15:0] pdat  [2][4];
    logic        e_vv, e_ack, slot;
    logic [12:0] e_addr;
    logic [1:0]  e_we;
    int          lat;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            lat = (k == 0) ? 1 : 2;
            if (rst) begin
                phase[k] = 0; mvd[k] = '0; mcr[k] = '0; mlast[k] = '0;
                for (int j = 0; j < 4; j++) pv[k][j] = 1'b0;
                if (ram_preload) begin
                    mmem[k][13'h0123] = 16'hBEEF;
                    mmem[k][13'h0010] = 16'h0000;
                    mmem[k][13'h0020] = 16'h0000;
                    mmem[k][13'h0030] = 16'h0000;
                    mmem[k][13'h0040] = 16'h0000;
                    ack_cnt[k] = 0;
                end
            end else begin
                e_vv = pv[k][cyc % 4];
                if (e_vv) begin
                    mvd[k] = pdat[k][cyc % 4];
                    pv[k][cyc % 4] = 1'b0;
                end
                e_ack = (phase[k] == 2) && (ack_at[k] == cyc);
                if (e_ack && !b_we[k]) mcr[k] = rd_val[k];
                slot   = !ce && (phase[k] == 1) && ((k == 0) || vblank);
                e_addr = ce ? vaddr : (slot ? b_addr[k] : mlast[k]);
                e_we   = (slot && b_we[k]) ? b_be[k] : 2'b00;

                chk($sformatf("ram_addr[%0d]", k), 32'(o_addr[k]), 32'(e_addr));
                chk($sformatf("ram_we[%0d]", k), 32'(o_we[k]), 32'(e_we));
                if (e_we != 2'b00) chk($sformatf("ram_wdata[%0d]", k), 32'(o_wd[k]), 32'(b_wd[k]));
                chk($sformatf("vid_valid[%0d]", k), 32'(o_vv[k]), 32'(e_vv));
                chk($sformatf("vid_data[%0d]", k), 32'(o_vd[k]), 32'(mvd[k]));
                chk($sformatf("cpu_ack[%0d]", k), 32'(o_ack[k]), 32'(e_ack));
                chk($sformatf("cpu_rdata[%0d]", k), 32'(o_rdata[k]), 32'(mcr[k]));
                if (o_ack[k]) ack_cnt[k]++;

                if (ce) begin
                    pv[k][(cyc + lat + 1) % 4]   = 1'b1;
                    pdat[k][(cyc + lat + 1) % 4] = mmem[k][vaddr];
                    mlast[k] = vaddr;
                end
                if (slot) begin
                    if (b_we[k]) begin
                        if (b_be[k][0]) mmem[k][b_addr[k]][7:0]  = b_wd[k][7:0];
                        if (b_be[k][1]) mmem[k][b_addr[k]][15:8] = b_wd[k][15:8];
                        ack_at[k] = cyc + 1;
                    end else begin
                        rd_val[k] = mmem[k][b_addr[k]];
                        ack_at[k] = cyc + lat + 1;
                    end
                    phase[k] = 2;
                end else if (phase[k] == 0 && req[k]) begin
                    b_we[k] = cwe[k]; b_be[k] = cbe[k]; b_addr[k] = caddr[k]; b_wd[k] = cwd[k];
                    phase[k] = 1;
                end else if (e_ack) begin
                    phase[k] = 3;
                end else if (phase[k] == 3 && !req[k]) begin
                    phase[k] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ce = (ce_mode == 2) || (ce_mode == 1 && (cyc % 4) == 0);
    endtask

    task automatic cpu_xfer(input int k, input logic we, input logic [1:0] be,
                            input logic [12:0] a, input logic [15:0] d,
                            input int hold, output logic ok);
        tick();
        req[k] = 1'b1; cwe[k] = we; cbe[k] = be; caddr[k] = a; cwd[k] = d;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick();
            #2;
            if (o_ack[k]) ok = 1'b1;
        end
        repeat (hold) tick();
        req[k] = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    logic ok;
    int   last_s, acks0, wrs0, exp_cyc;

    initial begin
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; cwe[k] = 1'b0; cbe[k] = 2'b00; caddr[k] = '0; cwd[k] = '0;
        end
        repeat (3) @(posedge clk);
        #3;
        chk("reset vid_data A", 32'(bus_a.vid_data), 32'h0);
        chk("reset vid_valid A", 32'(bus_a.vid_valid), 32'h0);
        chk("reset cpu_ack A", 32'(bus_a.cpu_ack), 32'h0);
        chk("reset cpu_rdata A", 32'(bus_a.cpu_rdata), 32'h0);
        chk("reset ram_we A", 32'(bus_a.ram_we), 32'h0);
        chk("reset ram_we B", 32'(bus_b.ram_we), 32'h0);
        ram_preload = 1'b0;
        rst = 1'b0;

        // Video only: strobe every 4th clock on 0x0123.
        ce_mode = 1;
        last_s = -100;
        for (int i = 0; i < 16; i++) begin
            tick();
            #2;
            if (ce) last_s = cyc;
            if (cyc == last_s + 1) chk("vid_valid early A", 32'(bus_a.vid_valid), 32'h0);
            if (cyc == last_s + 2) begin
                chk("vid_valid lat A", 32'(bus_a.vid_valid), 32'h1);
                chk("vid_data A", 32'(bus_a.vid_data), 32'hBEEF);
            end
        end

        // CPU write raised one clock before two pixel clocks.
        ce_mode = 0;
        tick();
        req[0] = 1'b1; cwe[0] = 1'b1; cbe[0] = 2'b01; caddr[0] = 13'h0010; cwd[0] = 16'hA55A;
        ce_mode = 2; tick(); tick();
        ce_mode = 0; tick();
        #2;
        chk("write slot ram_we", 32'(bus_a.ram_we), 32'h1);
        chk("write slot ram_addr", 32'(bus_a.ram_addr), 32'h0010);
        tick();
        #2;
        chk("write ack", 32'(bus_a.cpu_ack), 32'h1);
        chk("ram low byte", 32'(ram[0][13'h0010]), 32'h005A);
        req[0] = 1'b0;
        tick(); tick();

        // CPU read interleaved with pixels.
        ce_mode = 1;
        cpu_xfer(0, 1'b0, 2'b00, 13'h0010, 16'h0, 0, ok);
        chk("read ack seen", 32'(ok), 32'h1);
        chk("read data", 32'(bus_a.cpu_rdata), 32'h005A);

        // Held request: one ack, one write.
        acks0 = ack_cnt[0]; wrs0 = wr_cnt[0];
        cpu_xfer(0, 1'b1, 2'b11, 13'h0020, 16'h1234, 20, ok);
        chk("held ack seen", 32'(ok), 32'h1);
        chk("held ack count", 32'(ack_cnt[0] - acks0), 32'h1);
        chk("held write count", 32'(wr_cnt[0] - wrs0), 32'h1);
        cpu_xfer(0, 1'b0, 2'b00, 13'h0020, 16'h0, 0, ok);
        chk("reread ack seen", 32'(ok), 32'h1);
        chk("reread data", 32'(bus_a.cpu_rdata), 32'h1234);

        // Byte enables 00: acked, nothing written.
        wrs0 = wr_cnt[0];
        cpu_xfer(0, 1'b1, 2'b00, 13'h0020, 16'hFFFF, 0, ok);
        chk("be00 ack seen", 32'(ok), 32'h1);
        chk("be00 no write", 32'(wr_cnt[0] - wrs0), 32'h0);
        chk("be00 ram kept", 32'(ram[0][13'h0020]), 32'h1234);

        // Asynchronous reset while a write is parked behind pixel clocks.
        ce_mode = 2;
        tick();
        req[0] = 1'b1; cwe[0] = 1'b1; cbe[0] = 2'b11; caddr[0] = 13'h0030; cwd[0] = 16'h7777;
        tick(); tick(); tick();
        acks0 = ack_cnt[0]; wrs0 = wr_cnt[0];
        #2;
        rst = 1'b1;
        #1;
        chk("reset ram_we now", 32'(bus_a.ram_we), 32'h0);
        chk("reset no ack", 32'(bus_a.cpu_ack), 32'h0);
        chk("reset vid_data", 32'(bus_a.vid_data), 32'h0);
        req[0] = 1'b0;
        ce_mode = 0;
        tick(); tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("reset dropped write", 32'(wr_cnt[0] - wrs0), 32'h0);
        chk("reset dropped ack", 32'(ack_cnt[0] - acks0), 32'h0);
        chk("reset ram kept", 32'(ram[0][13'h0030]), 32'h0);

        // BLANK_ONLY instance: no issue until vblank, then first non-pixel clock.
        ce_mode = 1;
        vblank = 1'b0;
        wrs0 = wr_cnt[1]; acks0 = ack_cnt[1];
        tick();
        req[1] = 1'b1; cwe[1] = 1'b1; cbe[1] = 2'b11; caddr[1] = 13'h0040; cwd[1] = 16'hCAFE;
        repeat (100) tick();
        chk("blank no write", 32'(wr_cnt[1] - wrs0), 32'h0);
        chk("blank no ack", 32'(ack_cnt[1] - acks0), 32'h0);
        tick();
        vblank = 1'b1;
        exp_cyc = ce ? cyc + 1 : cyc;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #2;
            if (bus_b.cpu_ack) ok = 1'b1;
            if (!ok) tick();
        end
        chk("blank ack seen", 32'(ok), 32'h1);
        chk("blank issue cycle", 32'(wr_cyc[1]), 32'(exp_cyc));
        req[1] = 1'b0;
        tick(); tick();
        chk("blank ram data", 32'(ram[1][13'h0040]), 32'hCAFE);
        vblank = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
